// File: rtl/text_scan_sequencer_pkg.sv
// Shared state encoding and default geometry for the text scan sequencer.
package text_scan_sequencer_pkg;

  // Frame sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scanState_t;

  // 128x64 display, 8 pixel rows per byte
  localparam int unsigned DEF_NUM_BYTES    = 1024;
  localparam int unsigned DEF_ADDR_W       = 10;
  // One clock for the char row lookup, one for the font register
  localparam int unsigned DEF_READ_LATENCY = 2;
  localparam int unsigned DEF_FIFO_DEPTH   = 4;

endpackage

// File: rtl/text_byte_fifo.sv
// Small synchronous FIFO holding realigned font bytes ahead of the byte sender.
module text_byte_fifo
  import text_scan_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             wrEn;
  logic             rdEn;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign dout  = mem[rdPtr];

  // A push into a full FIFO is only taken when a pop frees the slot in the same cycle
  assign rdEn = pop && !empty;
  assign wrEn = push && (!full || rdEn);

  // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (wrEn) begin
        mem[wrPtr] <= din;
        wrPtr      <= wrPtr + PTR_W'(1);
      end
      if (rdEn) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      case ({wrEn, rdEn})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/text_scan_sequencer.sv
// Walks the text engine over one frame of pixel addresses, realigns the returned font
// bytes to the engine's read latency and streams them to the OLED byte sender.
module text_scan_sequencer
  import text_scan_sequencer_pkg::*;
#(
  parameter int unsigned NUM_BYTES    = DEF_NUM_BYTES,
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned READ_LATENCY = DEF_READ_LATENCY,
  parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              frame_start,
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W-1:0] pixel_address,
  input  logic [7:0]        pixel_data,
  output logic              byte_valid,
  output logic [7:0]        byte_data,
  input  logic              byte_ready
);

  localparam int unsigned IDX_W = ADDR_W + 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OUT_W = $clog2(FIFO_DEPTH + READ_LATENCY + 2) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BYTES - 1);
  localparam logic [OUT_W-1:0] DEPTH_LIM = OUT_W'(FIFO_DEPTH);

  scanState_t              state;
  logic [IDX_W-1:0]        idx;
  logic                    issueQ;
  logic [READ_LATENCY-1:0] issuePipe;
  logic                    capture;
  logic [OUT_W-1:0]        outstanding;
  logic                    issue;
  logic                    lastIssue;
  logic                    drainDone;

  logic [CNT_W-1:0]        fifoCount;
  logic                    fifoEmpty;
  logic                    fifoFull;
  logic                    fifoPop;

  // issueQ marks the cycle an address is on the bus; its byte arrives READ_LATENCY clocks later
  assign capture = issuePipe[READ_LATENCY-1];

  assign fifoPop    = !fifoEmpty && byte_ready;
  assign byte_valid = !fifoEmpty;

  // Bytes owed to the FIFO: address on the bus, reads in flight, and bytes already buffered
  always_comb begin
    outstanding = OUT_W'(fifoCount) + OUT_W'(issueQ);
    for (int i = 0; i < int'(READ_LATENCY); i++) begin
      outstanding = outstanding + OUT_W'(issuePipe[i]);
    end
  end

  // Credit check: a pop this cycle frees a slot, which keeps full rate at steady state
  assign issue = ((state == IDLE && frame_start) || state == FETCH)
                 && (outstanding < DEPTH_LIM + OUT_W'(fifoPop));
  assign lastIssue = issue && (idx == LAST_IDX);

  // Frame is finished once nothing is in flight and the last buffered byte leaves this cycle
  assign drainDone = !issueQ && (issuePipe == '0)
                     && (fifoEmpty || (fifoCount == CNT_W'(1) && fifoPop));

  // Frame FSM, address counter and registered status outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      idx           <= '0;
      pixel_address <= '0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            state <= lastIssue ? DRAIN : FETCH;
            busy  <= 1'b1;
          end
        end
        FETCH: begin
          if (lastIssue) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drainDone) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          idx   <= '0;
        end
        default: state <= IDLE;
      endcase
      if (issue) begin
        pixel_address <= idx[ADDR_W-1:0];
        idx           <= idx + IDX_W'(1);
      end
    end
  end

  // Issue strobe delayed to line up with the returned font byte
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      issueQ    <= 1'b0;
      issuePipe <= '0;
    end else begin
      issueQ       <= issue;
      issuePipe[0] <= issueQ;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        issuePipe[i] <= issuePipe[i-1];
      end
    end
  end

  text_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) uFifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (capture),
    .din    (pixel_data),
    .pop    (fifoPop),
    .dout   (byte_data),
    .count  (fifoCount),
    .empty  (fifoEmpty),
    .full   (fifoFull)
  );

  // The credit rule must make a capture into a full FIFO impossible
  noPushWhenFull: assert property (@(posedge clk) disable iff (!resetn) !(capture && fifoFull));

endmodule

// File: tb/tb_text_scan_sequencer.sv
module tb_text_scan_sequencer;

  logic clk;
  logic resetn;
  logic byteReady;
  logic readyOne;
  logic frameStartA, frameStartB, frameStartC;

  logic       busyA, doneA, validA;
  logic [9:0] addrA;
  logic [7:0] dataA, pixA;
  logic       busyB, doneB, validB;
  logic [9:0] addrB;
  logic [7:0] dataB, pixB;
  logic       busyC, doneC, validC;
  logic [9:0] addrC;
  logic [7:0] dataC, pixC;

  logic [7:0] engA [2];
  logic [7:0] engB;
  logic [7:0] engC [3];

  int total = 0;
  int bad   = 0;
  int accA  = 0;
  logic [7:0] expQ [$];

  text_scan_sequencer dutA (
    .clk(clk), .resetn(resetn), .frame_start(frameStartA), .busy(busyA), .frame_done(doneA),
    .pixel_address(addrA), .pixel_data(pixA), .byte_valid(validA), .byte_data(dataA),
    .byte_ready(byteReady));

  text_scan_sequencer #(.READ_LATENCY(1), .FIFO_DEPTH(8)) dutB (
    .clk(clk), .resetn(resetn), .frame_start(frameStartB), .busy(busyB), .frame_done(doneB),
    .pixel_address(addrB), .pixel_data(pixB), .byte_valid(validB), .byte_data(dataB),
    .byte_ready(readyOne));

  text_scan_sequencer #(.READ_LATENCY(3), .FIFO_DEPTH(8)) dutC (
    .clk(clk), .resetn(resetn), .frame_start(frameStartC), .busy(busyC), .frame_done(doneC),
    .pixel_address(addrC), .pixel_data(pixC), .byte_valid(validC), .byte_data(dataC),
    .byte_ready(readyOne));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Text engine models: data = addr[7:0] ^ A5, READ_LATENCY clocks after the address
  always @(posedge clk) begin
    engA[0] <= addrA[7:0] ^ 8'hA5;
    engA[1] <= engA[0];
    engB    <= addrB[7:0] ^ 8'hA5;
    engC[0] <= addrC[7:0] ^ 8'hA5;
    engC[1] <= engC[0];
    engC[2] <= engC[1];
  end
  assign pixA = engA[1];
  assign pixB = engB;
  assign pixC = engC[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive inputs for the next edge, score any byte accepted on it, advance one clock
  task automatic stepA(input logic rdy, input logic fs);
    logic [7:0] e;
    byteReady   = rdy;
    frameStartA = fs;
    if (validA && rdy) begin
      accA++;
      check("sb_has_entry", 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        check("byte_data", 32'(dataA), 32'(e));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // mode 0: ready held high, 1: random ready ~70% high, 2: 50-clock stall at cycle 100
  task automatic runFrame(input int mode, input bit extraStarts);
    int rel, doneAt, doneCnt, accStart;
    logic rdy;
    for (int i = 0; i < 1024; i++) expQ.push_back(8'(i) ^ 8'hA5);
    accStart = accA;
    stepA(1'b1, 1'b1);
    rel = 0; doneAt = -1; doneCnt = 0;
    while (rel < 8000) begin
      if (doneAt >= 0 && rel == doneAt + 20) break;
      if (doneA) begin
        doneCnt++;
        if (doneAt < 0) doneAt = rel;
      end
      if (rel == 0) begin
        check("busy_after_start", 32'(busyA), 32'd1);
        check("first_address", 32'(addrA), 32'd0);
      end
      if (mode == 0 && (rel == 1 || rel == 2)) check("valid_too_early", 32'(validA), 32'd0);
      if (mode == 0 && rel == 3) begin
        check("first_valid_cycle3", 32'(validA), 32'd1);
        check("first_byte", 32'(dataA), 32'hA5);
      end
      if (mode == 0 && doneAt >= 0 && rel == doneAt) begin
        check("frame_done_cycle", 32'(doneAt), 32'd1027);
        check("busy_in_done", 32'(busyA), 32'd1);
      end
      if (doneAt >= 0 && rel == doneAt + 1) begin
        check("busy_low_after", 32'(busyA), 32'd0);
        check("done_one_cycle", 32'(doneA), 32'd0);
      end
      if (mode == 2 && (rel == 120 || rel == 149)) begin
        check("stall_addr_held", 32'(addrA), 32'd100);
        check("stall_valid", 32'(validA), 32'd1);
        check("stall_head", 32'(dataA), 32'(8'(97) ^ 8'hA5));
      end
      case (mode)
        1:       rdy = ($urandom_range(0, 9) >= 3);
        2:       rdy = !(rel >= 100 && rel < 150);
        default: rdy = 1'b1;
      endcase
      stepA(rdy, extraStarts && (rel == 10 || rel == 1027));
      rel++;
    end
    check("frame_done_count", 32'(doneCnt), 32'd1);
    check("bytes_accepted", 32'(accA - accStart), 32'd1024);
    check("sb_empty", 32'(expQ.size()), 32'd0);
    check("busy_idle_end", 32'(busyA), 32'd0);
  endtask

  // Free-running frame on one of the parameter-sweep instances
  task automatic runSweep(input int which, input int rl);
    logic [7:0] q [$];
    logic [7:0] e;
    int rel, firstAt, n;
    logic v, fd;
    logic [7:0] d;
    bit done;
    for (int i = 0; i < 1024; i++) q.push_back(8'(i) ^ 8'hA5);
    if (which == 1) frameStartB = 1'b1; else frameStartC = 1'b1;
    @(posedge clk);
    @(negedge clk);
    frameStartB = 1'b0;
    frameStartC = 1'b0;
    rel = 0; firstAt = -1; n = 0; done = 1'b0;
    while (rel < 3000 && !done) begin
      v  = (which == 1) ? validB : validC;
      d  = (which == 1) ? dataB : dataC;
      fd = (which == 1) ? doneB : doneC;
      if (v) begin
        if (firstAt < 0) firstAt = rel;
        n++;
        check("sweep_sb_has_entry", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("sweep_byte", 32'(d), 32'(e));
        end
      end
      if (fd) done = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rel++;
    end
    check("sweep_first_latency", 32'(firstAt), 32'(rl + 1));
    check("sweep_count", 32'(n), 32'd1024);
    check("sweep_done", 32'(done), 32'd1);
  endtask

  initial begin
    int guard;
    bit sawDone;
    resetn = 1'b0; byteReady = 1'b0; readyOne = 1'b1;
    frameStartA = 1'b0; frameStartB = 1'b0; frameStartC = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busyA), 32'd0);
    check("rst_done", 32'(doneA), 32'd0);
    check("rst_valid", 32'(validA), 32'd0);
    check("rst_addr", 32'(addrA), 32'd0);
    check("rst_data", 32'(dataA), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    runFrame(0, 1'b0);   // free run
    runFrame(1, 1'b0);   // random backpressure
    runFrame(2, 1'b0);   // long stall
    runFrame(0, 1'b1);   // extra frame_start pulses ignored

    // Reset in the middle of a frame
    for (int i = 0; i < 1024; i++) expQ.push_back(8'(i) ^ 8'hA5);
    guard = accA;
    sawDone = 1'b0;
    stepA(1'b1, 1'b1);
    for (int c = 0; c < 2000 && (accA - guard) < 500; c++) begin
      if (doneA) sawDone = 1'b1;
      stepA(1'b1, 1'b0);
    end
    check("midframe_reached_500", 32'(accA - guard), 32'd500);
    check("midframe_no_done", 32'(sawDone), 32'd0);
    resetn = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busyA), 32'd0);
    check("mid_rst_done", 32'(doneA), 32'd0);
    check("mid_rst_valid", 32'(validA), 32'd0);
    check("mid_rst_addr", 32'(addrA), 32'd0);
    check("mid_rst_data", 32'(dataA), 32'd0);
    expQ.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    runFrame(0, 1'b0);

    runSweep(1, 1);
    runSweep(2, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
